// File: rtl/apb_cfg_regbank.sv
// apb_cfg_regbank
// ---------------------------------------------------------------------------
// APB4 slave holding NUM_REGS word-addressed configuration registers. All
// registers are presented to the TPU datapath as one flat bus.
//
//   reg0 CTRL   : bit0 START (write-1 strobe, reads 0), bit1 IRQ_ENABLE,
//                 remaining bits plain storage
//   reg1 STATUS : bit0 BUSY, bit1 DONE (sticky, W1C), bit2 START_ERR
//                 (sticky, W1C); all other bits read 0
//   reg2..      : generic RW registers with byte-lane strobes
//
// Optional feature macro: CFG_IRQ_EN
//   defined   -> irq is a registered copy of STATUS.DONE & CTRL.IRQ_ENABLE
//   undefined -> irq is tied low (IRQ_ENABLE is still stored and readable)
//
// Ports
//   PCLK, PRESETn       clock, asynchronous active-low reset
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA/PSTRB   APB request
//   PRDATA/PREADY/PSLVERR                    APB response
//   done_i              job-finished level from the TPU
//   start_pulse         one-cycle start strobe to the TPU
//   irq                 interrupt
//   cfg_flat            all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//
// States
//   state    | meaning
//   S_IDLE   | waiting for a setup phase (PSEL & !PENABLE)
//   S_ACCESS | access phase; counts wait states, completes when cnt hits
//            | WAIT_STATES, aborts if PSEL drops
// ---------------------------------------------------------------------------
module apb_cfg_regbank #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 24,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_FLAT = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic                           done_i,
    output logic                           start_pulse,
    output logic                           irq,
    output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_flat
);

    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam int         IDX_W  = ADDR_WIDTH - 2;
    localparam logic [3:0] WS     = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  start_pulse_q, start_pulse_d;
    logic                  irq_q, irq_d;

    logic [IDX_W-1:0]      idx_q;
    logic                  acc_err;
    logic                  commit;
    logic                  start_req;
    logic                  start_fire;
    logic                  status_w1c;
    logic                  busy_d, done_d, serr_d;

    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || (32'(a[ADDR_WIDTH-1:2]) >= NUM_REGS);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // START never holds a 1 and STATUS has no meaningful reset image, so both
    // are forced to 0 regardless of RESET_FLAT.
    function automatic logic [DATA_WIDTH-1:0] reset_word(input int i);
        logic [DATA_WIDTH-1:0] r;
        r = RESET_FLAT[i*DATA_WIDTH +: DATA_WIDTH];
        if (i == 0) r[0] = 1'b0;
        if (i == 1) r = '0;
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [IDX_W-1:0] idx);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == i[IDX_W-1:0]) r = regs_q[i];
        end
        return r;
    endfunction

    assign idx_q   = addr_q[ADDR_WIDTH-1:2];
    assign acc_err = addr_bad(addr_q);

    // Transfer FSM
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        prdata_d = prdata_q;
        commit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    cnt_d   = 4'd0;
                    state_d = S_ACCESS;
                    // Read data is captured at setup so it is stable for the
                    // whole access phase, however many wait states follow.
                    if (!PWRITE) begin
                        prdata_d = addr_bad(PADDR) ? '0 : read_reg(PADDR[ADDR_WIDTH-1:2]);
                    end
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                end else if (cnt_q == WS) begin
                    state_d = S_IDLE;
                    commit  = write_q && !acc_err;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register next-state
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        start_req  = 1'b0;
        status_w1c = 1'b0;
        if (commit) begin
            for (int i = 2; i < NUM_REGS; i++) begin
                if (idx_q == i[IDX_W-1:0]) regs_d[i] = lane_merge(regs_q[i], wdata_q, strb_q);
            end
            if (idx_q == '0) begin
                regs_d[0]    = lane_merge(regs_q[0], wdata_q, strb_q);
                regs_d[0][0] = 1'b0;
                start_req    = strb_q[0] & wdata_q[0];
            end
            if (idx_q == IDX_W'(1)) status_w1c = strb_q[0];
        end

        start_fire = start_req && !regs_q[1][0];

        // A start in the same cycle as done_i leaves the new job busy.
        if (start_fire)  busy_d = 1'b1;
        else if (done_i) busy_d = 1'b0;
        else             busy_d = regs_q[1][0];

        // Set beats clear on the sticky bits.
        if (done_i && regs_q[1][0])          done_d = 1'b1;
        else if (status_w1c && wdata_q[1])   done_d = 1'b0;
        else                                 done_d = regs_q[1][1];

        if (start_req && regs_q[1][0])       serr_d = 1'b1;
        else if (status_w1c && wdata_q[2])   serr_d = 1'b0;
        else                                 serr_d = regs_q[1][2];

        regs_d[1]      = '0;
        regs_d[1][2:0] = {serr_d, done_d, busy_d};

        start_pulse_d = start_fire;

`ifdef CFG_IRQ_EN
        irq_d = regs_q[1][1] & regs_q[0][1];
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            strb_q        <= '0;
            prdata_q      <= '0;
            start_pulse_q <= 1'b0;
            irq_q         <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= reset_word(i);
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            strb_q        <= strb_d;
            prdata_q      <= prdata_d;
            start_pulse_q <= start_pulse_d;
            irq_q         <= irq_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign PRDATA      = prdata_q;
    assign PREADY      = (state_q == S_ACCESS) && (cnt_q == WS);
    assign PSLVERR     = PREADY && acc_err;
    assign start_pulse = start_pulse_q;
    assign irq         = irq_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: doc/apb_cfg_regbank.md
Name: apb_cfg_regbank

Overview:
Parametrised APB4 slave that holds a bank of NUM_REGS word-addressed configuration registers and drives them to the TPU datapath as one flat bus.
Successor to the fixed-map config block, with these additions:
- configurable wait states
- PSTRB byte-lane writes
- PSLVERR on bad accesses
- a self-clearing start pulse and sticky W1C done status
Sits between the host APB fabric and the TPU control/datapath.

Parameters:
ADDR_WIDTH, 8, PADDR width in bits (byte address).
DATA_WIDTH, 32, register and APB data width; must be a multiple of 8.
NUM_REGS, 24, number of registers; index = PADDR[ADDR_WIDTH-1:2]; must be >=3 and <= 2^(ADDR_WIDTH-2).
WAIT_STATES, 0, access-phase cycles with PREADY low before completion; range 0..15.
RESET_FLAT, 0, NUM_REGS*DATA_WIDTH reset image; register i resets to slice [i*DATA_WIDTH +: DATA_WIDTH].

Ports:
PCLK  in  1  clock
PRESETn  in  1  reset; asynchronous, active-low
PADDR  in  ADDR_WIDTH  byte address
PSEL  in  1  slave select
PENABLE  in  1  access phase
PWRITE  in  1  1=write
PWDATA  in  DATA_WIDTH  write data
PSTRB  in  DATA_WIDTH/8  byte write strobes
PRDATA  out  DATA_WIDTH  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error
done_i  in  1  level from TPU, job finished
start_pulse  out  1  one-cycle start strobe
irq  out  1  interrupt (see Optional Feature)
cfg_flat  out  NUM_REGS*DATA_WIDTH  all register values, reg i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (PRESETn low, asynchronous): state=IDLE, PRDATA=0, PREADY=0, PSLVERR=0, start_pulse=0, irq=0, regs=RESET_FLAT, except reg0 bit0 and all STATUS bits, which reset to 0.
- A reset mid-transfer aborts the transfer; no write is committed.

State machine:
- IDLE: on PSEL & !PENABLE (setup phase), latch PADDR, PWRITE, PWDATA and PSTRB; set wait counter cnt=0; go ACCESS.
  - For reads, PRDATA is loaded from the addressed register at this edge (0 if the access errors).
- ACCESS: PREADY=1 iff cnt==WAIT_STATES; otherwise cnt increments each cycle.
  - On the cycle with PREADY=1 the transfer completes and any write commits at that edge; go IDLE. Back-to-back transfers need a new setup phase.
  - If PSEL deasserts while in ACCESS: abort, no write, go IDLE.
- PREADY and PSLVERR are 0 outside the completion cycle. PRDATA holds its value until the next read.

Access rules and errors:
- Error (PSLVERR=1 at completion) when index >= NUM_REGS or PADDR[1:0] != 0.
- Errored write: no register changes. Errored read: PRDATA=0.
- Generic regs 2..NUM_REGS-1 are RW. Each byte lane b is written only if PSTRB[b]=1. A write with PSTRB=0 completes with no change.

Reg0 CTRL:
- bit0 START: writing 1 with PSTRB[0] set produces start_pulse high for exactly the cycle after the commit edge. Reads as 0.
- bit1 IRQ_ENABLE: RW.
- Other bits: RW storage.
- A START write while STATUS.BUSY=1 is ignored (no pulse) and sets STATUS.START_ERR.

Reg1 STATUS, read-only except W1C bits:
- bit0 BUSY: set when start_pulse fires; cleared when done_i=1. If start and done_i occur in the same cycle, BUSY=1.
- bit1 DONE: sticky; set when done_i=1 and BUSY=1; W1C. If set and clear occur in the same cycle, set wins.
- bit2 START_ERR: sticky; W1C.
- Writes to other STATUS bits are ignored and do not error.

cfg_flat is combinationally equal to current register contents; START reads 0 there as well.

Optional Feature:
CFG_IRQ_EN
- Defined: irq is registered: irq = STATUS.DONE & CTRL.IRQ_ENABLE, updating one cycle after either changes.
- Undefined: irq tied to 0; CTRL.IRQ_ENABLE is still stored and readable.

Test Plan:
1. WAIT_STATES=0: write 0xA5A5_1234 to 0x08 with PSTRB=0xF, then read 0x08 -> PREADY high in the first access cycle, PSLVERR=0, PRDATA=0xA5A5_1234, cfg_flat[95:64]=0xA5A5_1234.
2. WAIT_STATES=3: write 0x0000_00FF to 0x0C with PSTRB=0x1 over a reg holding 0x1111_1111 -> PREADY low for 3 access cycles, high on the 4th; reg=0x1111_11FF.
3. Read 0x60 (index 24 = NUM_REGS) and write to 0x09 (misaligned) -> PSLVERR=1 with PREADY; read PRDATA=0; no register changes.
4. Write 0x1 to 0x00 -> one-cycle start_pulse, BUSY=1. Write 0x1 again -> no pulse, START_ERR=1. Pulse done_i -> BUSY=0, DONE=1. Write 0x6 to 0x04 -> DONE=0, START_ERR=0.
5. With CFG_IRQ_EN and CTRL=0x2: complete a job -> irq=1 one cycle after DONE sets. W1C DONE in the same cycle as done_i=1 -> DONE stays 1.
6. Assert PRESETn low in the middle of the WAIT_STATES=3 write of scenario 2 -> immediate reset, target reg back to its RESET_FLAT value, PREADY=0.
